// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer and msip
// software interrupt behind a single-cycle memory-mapped slave port.
module clint_timer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  input  logic        halt,
  output logic        timer_irq,
  output logic        swi_irq
);

  localparam logic [15:0] OFF_MSIP   = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MT_LO  = 16'hBFF8;
  localparam logic [15:0] OFF_MT_HI  = 16'hBFFC;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        tirq_q, tirq_d;
  logic        swi_q, swi_d;

  logic [15:0] off;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_mt_lo;
  logic        sel_mt_hi;
  logic        mapped;
  logic        wr;
  logic        rd;
  logic        tick;
  logic [31:0] rd_mux;

  // Only the bits selected by BASE_MASK take part in decode.
  assign off = addr & BASE_MASK & 16'hFFFC;

  assign sel_msip   = (off == (OFF_MSIP   & BASE_MASK));
  assign sel_cmp_lo = (off == (OFF_CMP_LO & BASE_MASK));
  assign sel_cmp_hi = (off == (OFF_CMP_HI & BASE_MASK));
  assign sel_mt_lo  = (off == (OFF_MT_LO  & BASE_MASK));
  assign sel_mt_hi  = (off == (OFF_MT_HI  & BASE_MASK));

  assign mapped = sel_msip | sel_cmp_lo | sel_cmp_hi
                | sel_mt_lo | sel_mt_hi;

  assign wr = req & we;
  assign rd = req & ~we;

  assign tick = ~halt & (presc_q == DIV_LAST);

  always_comb begin
    presc_d = presc_q;
    if (!halt) begin
      if (tick) presc_d = '0;
      else      presc_d = presc_q + 16'd1;
    end
  end

  // A write to either half pre-empts the tick for that cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && sel_mt_lo) begin
      mtime_d[31:0] = wdata;
    end else if (wr && sel_mt_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      unique case (1'b1)
        sel_cmp_lo: mtimecmp_d[31:0]  = wdata;
        sel_cmp_hi: mtimecmp_d[63:32] = wdata;
        sel_msip:   msip_d            = wdata[0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_msip:   rd_mux = {31'd0, msip_q};
      sel_cmp_lo: rd_mux = mtimecmp_q[31:0];
      sel_cmp_hi: rd_mux = mtimecmp_q[63:32];
      sel_mt_lo:  rd_mux = mtime_q[31:0];
      sel_mt_hi:  rd_mux = mtime_q[63:32];
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd;
    err_d    = req & ~mapped;
    if (rd) rdata_d = rd_mux;
  end

  always_comb begin
    tirq_d = (mtime_q >= mtimecmp_q);
    swi_d  = msip_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      presc_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      tirq_q     <= 1'b0;
      swi_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      tirq_q     <= tirq_d;
      swi_q      <= swi_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign timer_irq = tirq_q;
  assign swi_irq   = swi_q;

endmodule
